bist_sched: RTL and testbench

BIST_SCHED -- requirements
Module: bist_sched

---
 rtl/bist_pkg.sv | 26 ++
 rtl/bist_sched_if.sv | 20 ++
 rtl/bist_misr.sv | 23 ++
 rtl/bist_sched.sv | 77 +++++++
 tb/tb_bist_sched.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared constants and types for the BIST scheduler: state codes, LFSR/MISR
// taps, pattern count type and the default seed.
package bist_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_INIT    = 3'd1;
  localparam state_t S_APPLY   = 3'd2;
  localparam state_t S_CAPTURE = 3'd3;
  localparam state_t S_COMPARE = 3'd4;

  localparam int LFSR_W   = 36;
  localparam int LFSR_TAP = 25;
  localparam int MISR_W   = 32;
  localparam int MISR_T1  = 22;
  localparam int MISR_T2  = 2;
  localparam int MISR_T3  = 1;

  typedef logic [15:0] cnt_t;

  localparam logic [LFSR_W-1:0] DEF_SEED = 36'h0_0000_0001;

  // x^36 + x^25 + 1, shifting toward the MSB
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_W-1] ^ v[LFSR_TAP-1]};
  endfunction
endpackage

// File: rtl/bist_sched_if.sv
// Run control, CUT pattern/response and result signals of the BIST scheduler.
interface bist_sched_if #(
  parameter int N_IN  = 35,
  parameter int N_OUT = 23
);
  logic             start;
  logic             abort;
  logic [N_OUT-1:0] cut_resp;
  logic [N_IN-1:0]  pat_out;
  logic             cut_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic [31:0]      sig;

  modport master (output start, abort, cut_resp,
                  input  pat_out, cut_en, busy, done, pass, sig);
  modport slave  (input  start, abort, cut_resp,
                  output pat_out, cut_en, busy, done, pass, sig);
endinterface

// File: rtl/bist_misr.sv
// 32-bit multiple-input signature register, taps 32/22/2/1, zero-extended input.
module bist_misr
  import bist_pkg::*;
#(
  parameter int N_OUT = 23
) (
  input  logic              ck,
  input  logic              rstn,
  input  logic              clr,
  input  logic              en,
  input  logic [N_OUT-1:0]  din,
  output logic [MISR_W-1:0] sig
);
  logic [MISR_W-1:0] shifted;

  assign shifted = {sig[MISR_W-2:0],
                    sig[MISR_W-1] ^ sig[MISR_T1-1] ^ sig[MISR_T2-1] ^ sig[MISR_T3-1]};

  always_ff @(posedge ck) begin
    if (!rstn || clr) sig <= '0;
    else if (en)      sig <= shifted ^ MISR_W'(din);
  end
endmodule

// File: rtl/bist_sched.sv
// BIST run scheduler: LFSR pattern source, pattern counter and run FSM around
// a MISR response compactor; result is a signature compare against GOLDEN.
module bist_sched
  import bist_pkg::*;
#(
  parameter int                N_IN   = 35,
  parameter int                N_OUT  = 23,
  parameter int                N_PAT  = 1024,
  parameter logic [LFSR_W-1:0] SEED   = DEF_SEED,
  parameter logic [MISR_W-1:0] GOLDEN = 32'h0000_0000
) (
  input logic        ck,
  input logic        rstn,
  bist_sched_if.slave bif
);
  state_t            state, state_nx;
  logic [LFSR_W-1:0] lfsr;
  cnt_t              cnt;
  logic              pass_q;
  logic              kill, capture, init, last;

  // abort wins over everything except reset and freezes both shift registers
  assign kill    = bif.abort && (state != S_IDLE);
  assign init    = (state == S_INIT) && !kill;
  assign capture = (state == S_CAPTURE) && !kill;
  assign last    = (cnt == cnt_t'(N_PAT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (bif.start) state_nx = S_INIT;
      S_INIT:    state_nx = S_APPLY;
      S_APPLY:   state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = last ? S_COMPARE : S_APPLY;
      S_COMPARE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (kill) state_nx = S_IDLE;
  end

  always_ff @(posedge ck) begin
    if (!rstn) begin
      state  <= S_IDLE;
      lfsr   <= SEED;
      cnt    <= '0;
      pass_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (init) begin
        lfsr   <= SEED;
        cnt    <= '0;
        pass_q <= 1'b0;
      end
      if (capture) begin
        lfsr <= lfsr_next(lfsr);
        cnt  <= cnt + 16'd1;
      end
      if (state == S_COMPARE && !kill) pass_q <= (bif.sig == GOLDEN);
      if (kill) pass_q <= 1'b0;
    end
  end

  bist_misr #(.N_OUT(N_OUT)) u_misr (
    .ck   (ck),
    .rstn (rstn),
    .clr  (init),
    .en   (capture),
    .din  (bif.cut_resp),
    .sig  (bif.sig)
  );

  assign bif.pat_out = lfsr[N_IN-1:0];
  assign bif.cut_en  = capture;
  assign bif.busy    = (state != S_IDLE);
  assign bif.done    = (state == S_COMPARE) && !kill;
  assign bif.pass    = pass_q;
endmodule

// File: tb/tb_bist_sched.sv
// Directed bench for bist_sched: a 1024-pattern instance and a 1-pattern
// instance with GOLDEN=5 share clock and reset.
module tb_bist_sched;
  logic ck, rstn;
  int   nchk = 0, nerr = 0;
  int   dc = 0, dc1 = 0;

  bist_sched_if #(.N_IN(35), .N_OUT(23)) bif  ();
  bist_sched_if #(.N_IN(35), .N_OUT(23)) bif1 ();

  bist_sched #(.N_IN(35), .N_OUT(23), .N_PAT(1024), .GOLDEN(32'h0)) u_dut (
    .ck(ck), .rstn(rstn), .bif(bif));
  bist_sched #(.N_IN(35), .N_OUT(23), .N_PAT(1), .GOLDEN(32'h5)) u_dut1 (
    .ck(ck), .rstn(rstn), .bif(bif1));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(posedge ck) begin
    if (bif.done === 1'b1)  dc  <= dc + 1;
    if (bif1.done === 1'b1) dc1 <= dc1 + 1;
  end

  function automatic logic [31:0] mstep(input logic [31:0] m, input logic [22:0] r);
    return {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ {9'd0, r};
  endfunction

  task automatic test_reset();
    rstn = 1'b0; bif.start = 0; bif.abort = 0; bif.cut_resp = '0;
    bif1.start = 0; bif1.abort = 0; bif1.cut_resp = '0;
    repeat (3) @(posedge ck);
    #1;
    nchk++; if (bif.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", bif.busy); end
    nchk++; if (bif.done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b exp 0", bif.done); end
    nchk++; if (bif.cut_en !== 1'b0) begin nerr++; $display("FAIL reset_cut_en got %b exp 0", bif.cut_en); end
    nchk++; if (bif.pat_out !== 35'h1) begin nerr++; $display("FAIL reset_pat_out got %h exp 1", bif.pat_out); end
    nchk++; if (bif.sig !== 32'h0) begin nerr++; $display("FAIL reset_sig got %h exp 0", bif.sig); end
    nchk++; if (bif.pass !== 1'b0) begin nerr++; $display("FAIL reset_pass got %b exp 0", bif.pass); end
    rstn = 1'b1;
    repeat (2) @(posedge ck);
    #1;
    nchk++; if (bif.busy !== 1'b0 || bif1.busy !== 1'b0) begin nerr++; $display("FAIL post_reset_busy got %b/%b exp 0/0", bif.busy, bif1.busy); end
    nchk++; if (dc !== 0 || dc1 !== 0) begin nerr++; $display("FAIL post_reset_done_count got %0d/%0d exp 0/0", dc, dc1); end
  endtask

  task automatic test_single();
    int got = 0;
    bif1.cut_resp = 23'h5;
    bif1.start = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge ck); #1;
      bif1.start = 1'b0;
      if (n == 2) begin
        nchk++; if (bif1.cut_en !== 1'b0 || bif1.pat_out !== 35'h1) begin nerr++; $display("FAIL single_apply cut_en %b pat %h exp 0 1", bif1.cut_en, bif1.pat_out); end
      end
      if (n == 3) begin
        nchk++; if (bif1.cut_en !== 1'b1) begin nerr++; $display("FAIL single_capture_cut_en got %b exp 1", bif1.cut_en); end
      end
      if (bif1.done === 1'b1 && got == 0) begin
        got = n;
        nchk++; if (bif1.pass !== 1'b0) begin nerr++; $display("FAIL single_pass_during_compare got %b exp 0", bif1.pass); end
      end
    end
    nchk++; if (got != 4) begin nerr++; $display("FAIL single_done_cycle got %0d exp 4", got); end
    nchk++; if (bif1.sig !== 32'h5) begin nerr++; $display("FAIL single_sig got %h exp 5", bif1.sig); end
    nchk++; if (bif1.pass !== 1'b1) begin nerr++; $display("FAIL single_pass got %b exp 1", bif1.pass); end
    nchk++; if (dc1 !== 1) begin nerr++; $display("FAIL single_done_pulses got %0d exp 1", dc1); end
    bif1.cut_resp = '0;
  endtask

  // full 1024-pattern run, optionally poking START during APPLY cycles
  task automatic test_full(input bit poke);
    int got = 0;
    int n = 0;
    bif.cut_resp = '0;
    bif.start = 1'b1;
    while (n < 2100 && got == 0) begin
      @(posedge ck); #1;
      n++;
      bif.start = poke && (n == 4);
      if (n == 3) begin
        nchk++; if (bif.pat_out !== 35'h1) begin nerr++; $display("FAIL full_pat_first got %h exp 1", bif.pat_out); end
      end
      if (n == 4) begin
        nchk++; if (bif.pat_out !== 35'h2) begin nerr++; $display("FAIL full_pat_after_cap1 got %h exp 2", bif.pat_out); end
      end
      if (n == 6) begin
        nchk++; if (bif.pat_out !== 35'h4 || bif.busy !== 1'b1) begin nerr++; $display("FAIL full_no_restart pat %h busy %b exp 4 1", bif.pat_out, bif.busy); end
      end
      if (n == 50) begin
        nchk++; if (bif.pat_out !== 35'h100_0000) begin nerr++; $display("FAIL full_pat_cap24 got %h exp 1000000", bif.pat_out); end
      end
      if (n == 52) begin
        nchk++; if (bif.pat_out !== 35'h200_0001) begin nerr++; $display("FAIL full_pat_cap25 got %h exp 2000001", bif.pat_out); end
      end
      if (bif.done === 1'b1) got = n;
    end
    bif.start = 1'b0;
    nchk++; if (got != 2050) begin nerr++; $display("FAIL full_done_cycle got %0d exp 2050", got); end
    nchk++; if (bif.sig !== 32'h0) begin nerr++; $display("FAIL full_sig got %h exp 0", bif.sig); end
    @(posedge ck); #1;
    nchk++; if (bif.pass !== 1'b1 || bif.busy !== 1'b0) begin nerr++; $display("FAIL full_result pass %b busy %b exp 1 0", bif.pass, bif.busy); end
  endtask

  task automatic test_abort();
    logic [31:0] m = '0;
    logic [22:0] r;
    int d0;
    // abort while idle must leave everything alone
    bif.abort = 1'b1;
    repeat (2) @(posedge ck);
    #1;
    bif.abort = 1'b0;
    nchk++; if (bif.busy !== 1'b0 || bif.pass !== 1'b1) begin nerr++; $display("FAIL abort_idle busy %b pass %b exp 0 1", bif.busy, bif.pass); end
    d0 = dc;
    bif.start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge ck); #1;
      bif.start = 1'b0;
      r = 23'(n * 32'h1357 + 32'h2a);
      bif.cut_resp = r;
      if (n == 3 || n == 5) m = mstep(m, r);
      bif.abort = (n == 7);
    end
    nchk++; if (bif.sig !== m || bif.busy !== 1'b1) begin nerr++; $display("FAIL abort_pre_sig got %h busy %b exp %h 1", bif.sig, bif.busy, m); end
    @(posedge ck); #1;
    bif.abort = 1'b0;
    nchk++; if (bif.busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got %b exp 0", bif.busy); end
    nchk++; if (bif.sig !== m) begin nerr++; $display("FAIL abort_sig_frozen got %h exp %h", bif.sig, m); end
    nchk++; if (bif.pass !== 1'b0) begin nerr++; $display("FAIL abort_pass got %b exp 0", bif.pass); end
    repeat (3) @(posedge ck);
    #1;
    nchk++; if (dc !== d0 || bif.sig !== m) begin nerr++; $display("FAIL abort_after done %0d sig %h exp %0d %h", dc, bif.sig, d0, m); end
    bif.cut_resp = '0;
  endtask

  task automatic test_back_to_back();
    int d1 = 0, d2 = 0;
    int n = 0;
    bif.start = 1'b1;
    while (n < 4300 && d2 == 0) begin
      @(posedge ck); #1;
      n++;
      if (bif.done === 1'b1) begin
        if (d1 == 0) d1 = n; else d2 = n;
      end
    end
    bif.start = 1'b0;
    nchk++; if (d1 != 2050) begin nerr++; $display("FAIL b2b_first_done got %0d exp 2050", d1); end
    nchk++; if (d2 - d1 != 2051) begin nerr++; $display("FAIL b2b_spacing got %0d exp 2051", d2 - d1); end
    repeat (2) @(posedge ck);
    #1;
    nchk++; if (bif.busy !== 1'b0) begin nerr++; $display("FAIL b2b_stop_busy got %b exp 0", bif.busy); end
  endtask

  task automatic test_reset_midrun();
    int d0;
    d0 = dc;
    bif.cut_resp = 23'h7;
    bif.start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge ck); #1;
      bif.start = 1'b0;
    end
    nchk++; if (bif.cut_en !== 1'b1 || bif.sig !== 32'h7) begin nerr++; $display("FAIL rstmid_pre cut_en %b sig %h exp 1 7", bif.cut_en, bif.sig); end
    rstn = 1'b0;
    @(posedge ck); #1;
    rstn = 1'b1;
    nchk++; if (bif.busy !== 1'b0 || bif.sig !== 32'h0) begin nerr++; $display("FAIL rstmid_state busy %b sig %h exp 0 0", bif.busy, bif.sig); end
    nchk++; if (bif.pat_out !== 35'h1 || bif.pass !== 1'b0) begin nerr++; $display("FAIL rstmid_pat pat %h pass %b exp 1 0", bif.pat_out, bif.pass); end
    repeat (6) @(posedge ck);
    #1;
    nchk++; if (dc !== d0 || bif.busy !== 1'b0) begin nerr++; $display("FAIL rstmid_no_done done %0d busy %b exp %0d 0", dc, bif.busy, d0); end
    bif.cut_resp = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full(1'b0);
    test_abort();
    test_full(1'b1);
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
